axi_lite_master: RTL and testbench
==================================

# axi_lite_master

Single-outstanding AXI4-Lite initiator that turns a simple command/response interface into AXI4-Lite read and write transactions. It sits on the requester side of the AXI-Lite RAM slave and lets local logic or a testbench read and write the RAM over the bus. Exactly one transaction is in flight at a time. All AXI and response outputs are registered.

## Interface
- ADDR_WIDTH, 8: byte-address width of cmd_addr, awaddr and araddr.
- DATA_WIDTH_BYTES, 4: data width in bytes; the data width in bits is DATA_WIDTH_BYTES*8.
- clk  in  1  the single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid / cmd_ready  in / out  1 each  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address, passed through unmodified.
- cmd_wdata / cmd_wstrb  in  DATA_WIDTH_BYTES*8 / DATA_WIDTH_BYTES  write data and byte strobes; ignored for reads.
- rsp_valid / rsp_ready  out / in  1 each  response handshake.
- rsp_data  out  DATA_WIDTH_BYTES*8  read data; 0 for writes.
- rsp_resp  out  2  bresp or rresp, passed through unmodified.
- awvalid, awaddr, awready: AXI write-address channel (awready is the only input).
- wvalid, wdata, wstrb, wready: AXI write-data channel (wready is the only input).
- bvalid, bresp, bready: AXI write-response channel (bready is the only output).
- arvalid, araddr, arready: AXI read-address channel (arready is the only input).
- rvalid, rdata, rresp, rready: AXI read-data channel (rready is the only output).

## Operation
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch the address, data, strobe and direction.
  - A write goes to WR_ADDR. A read goes to RD_ADDR.
- WR_ADDR / WR_DATA:
  - Present AW, then W; see Configuration for how the two channels are ordered.
  - Each valid stays high, with a stable payload, until its own handshake completes. It drops the cycle after.
- WR_RESP:
  - bready = 1.
  - On bvalid, latch bresp into rsp_resp, set rsp_data = 0 and go to RSP.
- RD_ADDR:
  - arvalid = 1 until arready, then go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid, latch rdata and rresp and go to RSP.
- RSP:
  - rsp_valid = 1, with data and resp held stable.
  - On rsp_ready, return to IDLE.
- cmd_ready is high only in IDLE, so there is never more than one transaction outstanding.
- Non-OKAY responses are returned as-is; they are not retried and do not cause an error state.
- Reset, including mid-transaction:
  - State returns to IDLE and cmd_ready = 1.
  - All valid and ready outputs go to 0. rsp_data, rsp_resp and all AXI payload outputs go to 0.
  - Any in-flight transaction is abandoned; the slave must be reset together with this block.

## Timing
- Command accepted at edge N. The first AXI valid (awvalid and/or wvalid, or arvalid) is high from N+1.
- Zero-wait slave, with the concurrent macro defined:
  - AW/W or AR handshake at edge N+1.
  - B or R handshake at edge N+2.
  - rsp_valid high after N+2.
  - rsp_ready=1 gives cmd_ready high again after edge N+3.
- Zero-wait slave, macro undefined: a write takes one more cycle.
- bready/rready are never asserted before the address handshake has completed.
- No combinational path exists from any input to any output.

## Configuration
- AXI_LITE_MASTER_CONCURRENT_AW_W_EN defined:
  - awvalid and wvalid rise together in WR_ADDR.
  - Independent done flags track the two handshakes; each valid drops after its own handshake.
  - The FSM enters WR_RESP when both handshakes are done, whether they complete on the same edge or on different edges. WR_DATA is unused.
- AXI_LITE_MASTER_CONCURRENT_AW_W_EN undefined:
  - WR_ADDR asserts only awvalid.
  - After the awready handshake, WR_DATA asserts wvalid.
  - After the wready handshake, the FSM enters WR_RESP.

## Test plan
- Write then read, zero-wait slave:
  - Write addr 0x04, data 0xDEADBEEF, strb 0xF. Expect rsp_resp=0, rsp_data=0, and rsp_valid 3 cycles after accept with the macro on.
  - Read 0x04. Expect rsp_data=0xDEADBEEF.
- Partial strobe: write 0x08, data 0x11223344, strb 0b0101, then read it back. Expect 0x00220044 with the RAM slave attached.
- Backpressure:
  - Slave holds awready low for 3 cycles and wready low for 5 cycles. Expect awaddr/wdata stable throughout and each valid dropping independently.
  - Hold rsp_ready low for 4 cycles. Expect the response held and cmd_ready=0.
- Error passthrough: slave returns rresp=2'b10 with rdata=0x0. Expect rsp_resp=2'b10 and the block back in IDLE.
- Reset mid-write: assert rst while awvalid=1 and awready=0. Expect all valids 0, cmd_ready=1 and rsp_valid=0 immediately; a following read completes normally.
- Build with the macro undefined: check that wvalid never rises before the AW handshake and that a zero-wait write takes 4 cycles to rsp_valid.

Source files
------------

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator bridging a command/response port to AXI4-Lite.
// Define AXI_LITE_MASTER_CONCURRENT_AW_W_EN to issue AW and W together; default issues W after AW.
module axi_lite_master #(
  parameter int ADDR_WIDTH       = 8,
  parameter int DATA_WIDTH_BYTES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [DATA_WIDTH_BYTES*8-1:0] cmd_wdata,
  input  logic [DATA_WIDTH_BYTES-1:0]   cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH_BYTES*8-1:0] rsp_data,
  output logic [1:0]                    rsp_resp,
  output logic                          awvalid,
  output logic [ADDR_WIDTH-1:0]         awaddr,
  input  logic                          awready,
  output logic                          wvalid,
  output logic [DATA_WIDTH_BYTES*8-1:0] wdata,
  output logic [DATA_WIDTH_BYTES-1:0]   wstrb,
  input  logic                          wready,
  input  logic                          bvalid,
  input  logic [1:0]                    bresp,
  output logic                          bready,
  output logic                          arvalid,
  output logic [ADDR_WIDTH-1:0]         araddr,
  input  logic                          arready,
  input  logic                          rvalid,
  input  logic [DATA_WIDTH_BYTES*8-1:0] rdata,
  input  logic [1:0]                    rresp,
  output logic                          rready
);

  localparam int DW = DATA_WIDTH_BYTES * 8;

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

  state_t                  state, state_n;
  logic                    cmd_ready_n, rsp_valid_n;
  logic [DW-1:0]           rsp_data_n;
  logic [1:0]              rsp_resp_n;
  logic                    awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
  logic [ADDR_WIDTH-1:0]   awaddr_n, araddr_n;
  logic [DW-1:0]           wdata_n;
  logic [DATA_WIDTH_BYTES-1:0] wstrb_n;

`ifdef AXI_LITE_MASTER_CONCURRENT_AW_W_EN
  logic aw_done, w_done, aw_done_n, w_done_n;
  logic aw_hs, w_hs;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
`endif

  // Every output is a register; the comb block only computes their next values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_resp  <= '0;
      awvalid   <= 1'b0;
      awaddr    <= '0;
      wvalid    <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      araddr    <= '0;
      rready    <= 1'b0;
`ifdef AXI_LITE_MASTER_CONCURRENT_AW_W_EN
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cmd_ready <= cmd_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
      rsp_resp  <= rsp_resp_n;
      awvalid   <= awvalid_n;
      awaddr    <= awaddr_n;
      wvalid    <= wvalid_n;
      wdata     <= wdata_n;
      wstrb     <= wstrb_n;
      bready    <= bready_n;
      arvalid   <= arvalid_n;
      araddr    <= araddr_n;
      rready    <= rready_n;
`ifdef AXI_LITE_MASTER_CONCURRENT_AW_W_EN
      aw_done   <= aw_done_n;
      w_done    <= w_done_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    cmd_ready_n = cmd_ready;
    rsp_valid_n = rsp_valid;
    rsp_data_n  = rsp_data;
    rsp_resp_n  = rsp_resp;
    awvalid_n   = awvalid;
    awaddr_n    = awaddr;
    wvalid_n    = wvalid;
    wdata_n     = wdata;
    wstrb_n     = wstrb;
    bready_n    = bready;
    arvalid_n   = arvalid;
    araddr_n    = araddr;
    rready_n    = rready;
`ifdef AXI_LITE_MASTER_CONCURRENT_AW_W_EN
    aw_done_n   = aw_done;
    w_done_n    = w_done;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          cmd_ready_n = 1'b0;
          if (cmd_write) begin
            awaddr_n  = cmd_addr;
            wdata_n   = cmd_wdata;
            wstrb_n   = cmd_wstrb;
            awvalid_n = 1'b1;
`ifdef AXI_LITE_MASTER_CONCURRENT_AW_W_EN
            wvalid_n  = 1'b1;
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
`endif
            state_n   = WR_ADDR;
          end else begin
            araddr_n  = cmd_addr;
            arvalid_n = 1'b1;
            state_n   = RD_ADDR;
          end
        end
      end
      WR_ADDR: begin
`ifdef AXI_LITE_MASTER_CONCURRENT_AW_W_EN
        // Handshakes may land on the same or different edges; sticky flags cover both.
        if (aw_hs) awvalid_n = 1'b0;
        if (w_hs)  wvalid_n  = 1'b0;
        aw_done_n = aw_done | aw_hs;
        w_done_n  = w_done | w_hs;
        if (aw_done_n && w_done_n) begin
          bready_n = 1'b1;
          state_n  = WR_RESP;
        end
`else
        if (awready) begin
          awvalid_n = 1'b0;
          wvalid_n  = 1'b1;
          state_n   = WR_DATA;
        end
`endif
      end
      WR_DATA: begin
        if (wready) begin
          wvalid_n = 1'b0;
          bready_n = 1'b1;
          state_n  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          bready_n    = 1'b0;
          rsp_resp_n  = bresp;
          rsp_data_n  = '0;
          rsp_valid_n = 1'b1;
          state_n     = RSP;
        end
      end
      RD_ADDR: begin
        if (arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          rready_n    = 1'b0;
          rsp_data_n  = rdata;
          rsp_resp_n  = rresp;
          rsp_valid_n = 1'b1;
          state_n     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          cmd_ready_n = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master with a small AXI-Lite RAM slave and a response scoreboard.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [7:0]  awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axi_lite_master #(.ADDR_WIDTH(8), .DATA_WIDTH_BYTES(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready)
  );

`ifdef AXI_LITE_MASTER_CONCURRENT_AW_W_EN
  localparam int WLAT0  = 3;
  localparam int WLATBP = 8;   // max(3,5) + 3
`else
  localparam int WLAT0  = 4;
  localparam int WLATBP = 12;  // 3 + 5 + 4
`endif

  // Slave: per-channel ready held low for a programmable number of valid cycles.
  int          aw_delay, w_delay, ar_delay;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic        cfg_rzero;
  int          aw_cnt, w_cnt, ar_cnt;
  logic        aw_got, w_got, a_ok, w_ok;
  logic [7:0]  aw_q, a_addr;
  logic [31:0] w_q, w_use;
  logic [3:0]  s_q, s_use;
  logic [31:0] mem [16];

  assign awready = (aw_cnt >= aw_delay);
  assign wready  = (w_cnt >= w_delay);
  assign arready = (ar_cnt >= ar_delay);
  assign a_ok    = aw_got || (awvalid && awready);
  assign w_ok    = w_got || (wvalid && wready);
  assign a_addr  = aw_got ? aw_q : awaddr;
  assign w_use   = w_got ? w_q : wdata;
  assign s_use   = w_got ? s_q : wstrb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      aw_q <= '0; w_q <= '0; s_q <= '0;
      bvalid <= 1'b0; bresp <= '0;
      rvalid <= 1'b0; rdata <= '0; rresp <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (awvalid && awready) aw_cnt <= 0; else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready)   w_cnt  <= 0; else if (wvalid)  w_cnt  <= w_cnt + 1;
      if (arvalid && arready) ar_cnt <= 0; else if (arvalid) ar_cnt <= ar_cnt + 1;
      if (a_ok && w_ok && !bvalid) begin
        for (int b = 0; b < 4; b++)
          if (s_use[b]) mem[a_addr[5:2]][b*8 +: 8] <= w_use[b*8 +: 8];
        bvalid <= 1'b1;
        bresp  <= cfg_bresp;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (awvalid && awready) begin aw_got <= 1'b1; aw_q <= awaddr; end
        if (wvalid && wready)   begin w_got <= 1'b1; w_q <= wdata; s_q <= wstrb; end
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= cfg_rzero ? 32'h0 : mem[araddr[5:2]];
        rresp  <= cfg_rresp;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  typedef struct packed { logic [31:0] data; logic [1:0] resp; } exp_t;
  exp_t        sb [$];
  logic [31:0] ref_mem [16];
  int          errors = 0;
  int          checks = 0;

  logic        p_rst, p_awvalid, p_awready, p_wvalid, p_wready, p_arvalid, p_arready;
  logic [7:0]  p_awaddr, p_araddr;
  logic [31:0] p_wdata;
  logic [3:0]  p_wstrb;
  logic        aw_seen, ar_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Advance to the next falling edge and check channel protocol against the previous sample.
  task automatic tick();
    @(negedge clk);
    if (!rst && !p_rst) begin
      if (p_awvalid && !p_awready) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (p_awvalid && p_awready)  chk("aw_drop", awvalid, 0);
      if (p_wvalid && !p_wready) begin
        chk("w_hold_ctl", {wvalid, wstrb}, {1'b1, p_wstrb});
        chk("w_hold_data", wdata, p_wdata);
      end
      if (p_wvalid && p_wready)    chk("w_drop", wvalid, 0);
      if (p_arvalid && !p_arready) chk("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
      if (p_arvalid && p_arready)  chk("ar_drop", arvalid, 0);
`ifndef AXI_LITE_MASTER_CONCURRENT_AW_W_EN
      if (wvalid) chk("w_before_aw", aw_seen, 1);
`endif
      if (bready) chk("bready_early", aw_seen, 1);
      if (rready) chk("rready_early", ar_seen, 1);
      if (awvalid && awready) aw_seen = 1'b1;
      if (arvalid && arready) ar_seen = 1'b1;
    end
    p_rst = rst;
    p_awvalid = awvalid; p_awready = awready; p_awaddr = awaddr;
    p_wvalid = wvalid; p_wready = wready; p_wdata = wdata; p_wstrb = wstrb;
    p_arvalid = arvalid; p_arready = arready; p_araddr = araddr;
  endtask

  task automatic do_cmd(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int rsp_hold, input int want_lat);
    int   n;
    int   lat;
    exp_t e;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("accept_wait", cmd_ready, 1);
    aw_seen = 1'b0;
    ar_seen = 1'b0;
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[addr[5:2]][b*8 +: 8] = data[b*8 +: 8];
      e.data = '0;
      e.resp = cfg_bresp;
    end else begin
      e.data = cfg_rzero ? 32'h0 : ref_mem[addr[5:2]];
      e.resp = cfg_rresp;
    end
    sb.push_back(e);
    tick();
    cmd_valid = 1'b0;
    chk("cmd_ready_busy", cmd_ready, 0);
    if (wr) begin
      chk("awvalid_first", awvalid, 1);
      chk("awaddr", awaddr, addr);
    end else begin
      chk("arvalid_first", arvalid, 1);
      chk("araddr", araddr, addr);
    end
    lat = 1;
    while (!rsp_valid && lat < 60) begin tick(); lat++; end
    chk("rsp_latency", lat, want_lat);
    e = sb.pop_front();
    for (int i = 0; i < rsp_hold; i++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_data", rsp_data, e.data);
      tick();
    end
    chk("rsp_data", rsp_data, e.data);
    chk("rsp_resp", rsp_resp, e.resp);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_done", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    aw_delay = 0; w_delay = 0; ar_delay = 0;
    cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rzero = 1'b0;
    aw_seen = 1'b0; ar_seen = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
    chk("rst_payload", {awaddr, araddr, wstrb, rsp_resp}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_wdata", wdata, 0);
    rst = 1'b0;
    tick();

    do_cmd(1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 0, WLAT0);
    do_cmd(1'b0, 8'h04, 32'h0, 4'h0, 0, 3);
    do_cmd(1'b1, 8'h08, 32'h11223344, 4'b0101, 0, WLAT0);
    do_cmd(1'b0, 8'h08, 32'h0, 4'h0, 4, 3);
    chk("partial_ref", ref_mem[2], 32'h00220044);

    aw_delay = 3; w_delay = 5;
    do_cmd(1'b1, 8'h0C, 32'hA5A55A5A, 4'hF, 0, WLATBP);
    aw_delay = 0; w_delay = 0;
    do_cmd(1'b0, 8'h0C, 32'h0, 4'h0, 0, 3);

    cfg_rresp = 2'b10; cfg_rzero = 1'b1;
    do_cmd(1'b0, 8'h04, 32'h0, 4'h0, 0, 3);
    cfg_rresp = 2'b00; cfg_rzero = 1'b0;

    // Abandon a write while AW is stalled.
    aw_delay = 10;
    cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("mid_accept_wait", cmd_ready, 1);
    aw_seen = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("mid_aw_stalled", {awvalid, awready}, 2'b10);
    rst = 1'b1;
    #1;
    chk("mid_rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_awaddr", awaddr, 0);
    tick();
    rst = 1'b0;
    aw_delay = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    tick();
    do_cmd(1'b0, 8'h04, 32'h0, 4'h0, 0, 3);
    do_cmd(1'b1, 8'h14, 32'h0BADCAFE, 4'hF, 0, WLAT0);
    do_cmd(1'b0, 8'h14, 32'h0, 4'h0, 0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
